// File: rtl/sliding_power_meter.sv
// sliding_power_meter: sliding-window mean-square power over NCH signed channels, 3-cycle latency
module sliding_power_meter #(
    parameter int DATA_W    = 24,
    parameter int NCH       = 2,
    parameter int LOG2_WIN  = 12,
    parameter int FRAC_DROP = 12,
    localparam int CW    = NCH > 1 ? $clog2(NCH) : 0,
    localparam int SUM_W = DATA_W + CW,
    localparam int SQ_W  = 2 * SUM_W - FRAC_DROP,
    localparam int ACC_W = SQ_W + LOG2_WIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  mode_sum,
    input  logic                  in_valid,
    input  logic [NCH*DATA_W-1:0] ch_in,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      sum_out,
    output logic [SQ_W-1:0]       mean_out,
    output logic                  window_full,
    output logic                  busy_fill
);
    localparam int PW = 2 * SUM_W;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state, state_n;
    logic restart, mode_r, v1, v2;
    logic signed [SUM_W-1:0] csum;
    logic [DATA_W-1:0] cabs [NCH];
    logic [DATA_W-1:0] mag_c [NCH];
    logic [SUM_W-1:0] mag_s;
    logic [PW-1:0] prod;
    logic [SQ_W-1:0] sq, term, oldest;
    logic [SQ_W-1:0] mem [2**LOG2_WIN];
    logic [LOG2_WIN-1:0] wr_ptr, rd_addr, count;
    logic [ACC_W-1:0] acc, acc_n;
    logic [ACC_W:0] acc_plus;

    assign restart = rst || clear;

    always_comb begin
        csum = '0;
        for (int i = 0; i < NCH; i++) begin
            csum = csum + SUM_W'($signed(ch_in[i*DATA_W +: DATA_W]));
            cabs[i] = ch_in[i*DATA_W+DATA_W-1] ? -ch_in[i*DATA_W +: DATA_W] : ch_in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        prod = mode_r ? PW'(mag_s) * PW'(mag_s) : '0;
        for (int i = 0; i < NCH; i++)
            prod = mode_r ? prod : prod + PW'(mag_c[i]) * PW'(mag_c[i]);
    end

    assign sq = SQ_W'(prod >> FRAC_DROP);
    // The term in stage 3 this edge occupies wr_ptr, so the next sample's oldest sits one slot ahead
    assign rd_addr = wr_ptr + LOG2_WIN'(v2);
    assign acc_plus = {1'b0, acc} + (ACC_W+1)'(term);
    assign acc_n = state == RUN ? acc_plus[ACC_W-1:0] - ACC_W'(oldest) : acc_plus[ACC_W-1:0];

    assign state_n = restart ? IDLE :
                     state == IDLE ? FILL :
                     (state == FILL && v2 && &count) ? RUN : state;

    always_ff @(posedge clk) state <= state_n;

    always_ff @(posedge clk) begin
        if (restart) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            v1        <= in_valid && state != IDLE;
            v2        <= v1;
            out_valid <= v2;
            if (state == IDLE) mode_r <= mode_sum;
            if (v2) begin
                acc    <= acc_n;
                wr_ptr <= wr_ptr + LOG2_WIN'(1);
                count  <= count + LOG2_WIN'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mag_s <= csum[SUM_W-1] ? -csum : csum;
            mag_c <= cabs;
        end
        if (v1) term <= sq;
        if (v1 && state_n == RUN) oldest <= mem[rd_addr];
        if (v2 && !restart) mem[wr_ptr] <= term;
    end

    assert property (@(posedge clk) disable iff (restart) (v2 && state == RUN) |-> acc_plus >= (ACC_W+1)'(oldest));

    assign sum_out     = acc;
    assign mean_out    = acc[ACC_W-1:LOG2_WIN];
    assign window_full = state == RUN;
    assign busy_fill   = state == FILL;
endmodule

// File: tb/tb_sliding_power_meter.sv
// tb_sliding_power_meter: directed plus random stimulus against a window-queue reference model
module tb_sliding_power_meter;
    localparam int DW = 24, NCH = 2, L2W = 2, FD = 0, WIN = 4;
    localparam int SQ_W = 50, ACC_W = 52;
    localparam int K_RST = 0, K_FILL = 1, K_SMP = 2;
    localparam int NEG = -8388608;

    typedef struct {int due; int kind; longint sum; bit full;} ev_t;

    logic clk = 1'b0;
    logic rst, clear, mode_sum, in_valid;
    logic [NCH*DW-1:0] ch_in;
    logic out_valid, window_full, busy_fill;
    logic [ACC_W-1:0] sum_out;
    logic [SQ_W-1:0] mean_out;

    sliding_power_meter #(.DATA_W(DW), .NCH(NCH), .LOG2_WIN(L2W), .FRAC_DROP(FD)) dut (
        .clk(clk), .rst(rst), .clear(clear), .mode_sum(mode_sum), .in_valid(in_valid),
        .ch_in(ch_in), .out_valid(out_valid), .sum_out(sum_out), .mean_out(mean_out),
        .window_full(window_full), .busy_fill(busy_fill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t q[$];
    longint win[$];
    bit m_idle = 1'b1, m_mode = 1'b0;
    int n_tests = 0, n_fail = 0;
    longint lsum = 0;
    bit lfull = 1'b0, lbusy = 1'b0, exp_ov;
    ev_t e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic longint term_of(input bit m, input int a, input int b);
        longint la = a, lb = b;
        return (m ? (la + lb) * (la + lb) : la * la + lb * lb) >>> FD;
    endfunction

    task automatic model(input bit r, input bit c, input bit v, input int a, input int b);
        longint s = 0;
        if (r || c) begin
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            q.push_back('{cyc + 1, K_RST, 0, 1'b0});
            q.push_back('{cyc + 2, K_FILL, 0, 1'b0});
            win.delete();
            m_idle = 1'b1;
        end else if (m_idle) begin
            m_mode = mode_sum;
            m_idle = 1'b0;
        end else if (v) begin
            win.push_back(term_of(m_mode, a, b));
            if (win.size() > WIN) void'(win.pop_front());
            foreach (win[i]) s += win[i];
            q.push_back('{cyc + 3, K_SMP, s, win.size() == WIN});
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit v, input int a, input int b);
        rst = r;
        clear = c;
        in_valid = v;
        ch_in = {b[DW-1:0], a[DW-1:0]};
        model(r, c, v, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) drive(0, 0, 1, a, b);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_ov = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.kind == K_RST) begin
                    lsum = 0; lfull = 1'b0; lbusy = 1'b0;
                end else if (e.kind == K_FILL) begin
                    lbusy = 1'b1;
                end else begin
                    exp_ov = 1'b1; lsum = e.sum; lfull = e.full; lbusy = !e.full;
                end
            end
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("sum_out", 64'(sum_out), lsum);
            chk("mean_out", 64'(mean_out), lsum >>> L2W);
            chk("window_full", 64'(window_full), 64'(lfull));
            chk("busy_fill", 64'(busy_fill), 64'(lbusy));
        end
    end

    initial begin
        mode_sum = 1'b1;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 4);
        samples(4, 3, 4);
        samples(4, 0, 0);
        gap(4);
        mode_sum = 1'b0;
        drive(0, 1, 0, 0, 0);
        gap(1);
        samples(4, 3, 4);
        gap(4);
        mode_sum = 1'b1;
        drive(0, 1, 0, 0, 0);
        gap(1);
        samples(4, NEG, NEG);
        gap(4);
        mode_sum = 1'b0;
        drive(0, 1, 0, 0, 0);
        gap(1);
        samples(4, NEG, NEG);
        mode_sum = 1'b1;
        samples(6, 100, -7);
        gap(3);
        samples(2, -5000, 123);
        samples(3, 11, 22);
        drive(0, 1, 0, 0, 0);
        gap(1);
        samples(4, 2, 9);
        samples(5, -3, 1);
        drive(1, 1, 1, 8, 8);
        gap(1);
        samples(4, 7, -1);
        gap(4);
        for (int i = 0; i < 600; i++) begin
            int a, b;
            a = ($urandom % 8 == 0) ? NEG : int'($urandom_range(0, 16777215)) - 8388608;
            b = ($urandom % 8 == 0) ? NEG : int'($urandom_range(0, 16777215)) - 8388608;
            if ($urandom % 8 == 0) mode_sum = ~mode_sum;
            drive($urandom % 150 == 0, $urandom % 60 == 0, $urandom % 10 < 7, a, b);
        end
        gap(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sliding_power_meter.md
Name: sliding_power_meter

Overview:
Parametrised sliding-window mean-square power meter for multi-channel signed audio/IF samples. Each accepted sample is reduced to one power term: either the square of the channel sum or the sum of per-channel squares. The term is scaled and pushed into a circular history buffer. A running window sum and its mean are maintained and updated on every accepted sample; the block feeds downstream RMS/level logic.

Parameters:
DATA_W, 24, width of each signed input channel
NCH, 2, number of input channels (>=1)
LOG2_WIN, 12, window length is 2^LOG2_WIN accepted samples
FRAC_DROP, 12, LSBs discarded from the power term before buffering
Derived (localparams):
- CW = clog2(NCH), 0 when NCH=1
- SUM_W = DATA_W+CW
- SQ_W = 2*SUM_W-FRAC_DROP
- ACC_W = SQ_W+LOG2_WIN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
clear  in  1  synchronous restart of window, one-cycle pulse
mode_sum  in  1  1 = square of channel sum; 0 = sum of per-channel squares
in_valid  in  1  sample strobe, qualifies ch_in
ch_in  in  NCH*DATA_W  packed signed channels, ch0 in LSBs
out_valid  out  1  one-cycle pulse, sum_out/mean_out updated
sum_out  out  ACC_W  window sum of power terms
mean_out  out  SQ_W  sum_out >> LOG2_WIN
window_full  out  1  window holds 2^LOG2_WIN terms
busy_fill  out  1  high while state is FILL

Behaviour:
- Reset / clear values: out_valid=0, sum_out=0, mean_out=0, window_full=0, busy_fill=0. Pointers and fill count are 0; pipeline valids are 0. Buffer contents are not cleared and are never read before being written.
- Mode latching: mode_sum is latched only in IDLE. Changing it mid-run has no effect until the next clear or rst.
- Stage 1 (in_valid cycle + 1): registers the magnitude.
  - Mode 1: sign-extend each channel to SUM_W, add all channels, register true absolute value (two's complement negate; -2^(SUM_W-1) yields 2^(SUM_W-1)).
  - Mode 0: register the absolute value of each channel separately.
- Stage 2 (+2): multiply.
  - Mode 1: square the registered magnitude.
  - Mode 0: sum of channel squares.
  - Drop FRAC_DROP LSBs (truncate) to give term, SQ_W bits unsigned; the term cannot overflow SQ_W.
  - Issue the synchronous buffer read at wr_ptr (oldest term).
- Stage 3 (+3): accumulate.
  - Update the accumulator and write term to buffer[wr_ptr].
  - Advance wr_ptr modulo 2^LOG2_WIN.
  - Assert out_valid with the new sum_out/mean_out.
  - Total latency is exactly 3 cycles from in_valid to out_valid.
- Throughput: one sample per cycle; back-to-back in_valid is supported. Gaps in in_valid leave the accumulator and outputs unchanged, and out_valid stays low.
- State machine:
  - IDLE: entered on rst or clear. Zero the accumulator, pointer and count; latch mode_sum. Move to FILL next cycle. in_valid during IDLE is ignored.
  - FILL: acc <= acc + term; count increments. On the stage-3 update where count becomes 2^LOG2_WIN, move to RUN and set window_full in the same cycle as that out_valid.
  - RUN: acc <= acc + term - oldest. The subtraction is exact and never underflows; add a simulation assertion on that. No clamping is applied.
- Wrap-around: wr_ptr wraps from 2^LOG2_WIN-1 to 0 with no bubble. The read of the oldest term always precedes the same-address write (read-before-write).
- clear or rst mid-operation: in-flight pipeline samples are discarded, producing no out_valid. Outputs go to reset values on the next edge. rst has priority over clear.
- ACC_W guarantees no accumulator overflow. mean_out is a combinational slice of the registered accumulator.

Test Plan:
- DATA_W=24, NCH=2, LOG2_WIN=2, FRAC_DROP=0, mode_sum=1. Stimulus: four samples ch0=3, ch1=4 -> sum_out 49, 98, 147, 196. window_full rises with the 4th out_valid, mean_out=49.
- Continue with four samples of 0,0 -> sum_out 147, 98, 49, 0. window_full stays 1. No underflow assertion fires.
- Same stimulus with mode_sum=0 (set before clear) -> per-sample term 25. After 4 samples sum_out=100, mean_out=25.
- Extreme input: ch0=ch1=-8388608, mode_sum=1 -> term 2^48. After 4 samples sum_out=2^50 with ACC_W=52 and no overflow. Mode 0 gives term 2^47.
- Latency/throughput: in_valid high 6 back-to-back cycles, then a 3-cycle gap, then 2 cycles -> out_valid pulses at exactly +3 cycles per sample. Outputs hold during the gap. Pointer wrap shows no bubble.
- Pulse clear with 2 samples in flight during RUN -> no out_valid for those samples. sum_out=0 and window_full=0 next cycle. Refill takes 4 new samples. A rst pulse gives the same result and overrides a simultaneous clear.
